// File: rtl/skew_pkg.sv
// -----------------------------------------------------------------------------
// skew_pkg
// Shared definitions for the skew feeder and the triangular array it drives:
//   - state_t        : feeder control states (IDLE, STREAM, DRAIN)
//   - DEFAULT_N_DIM  : default number of array columns
//   - DEFAULT_DATA_W : default element width
// -----------------------------------------------------------------------------
package skew_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam int DEFAULT_N_DIM  = 3;
    localparam int DEFAULT_DATA_W = 16;

endpackage

// File: rtl/skew_delay_line.sv
// -----------------------------------------------------------------------------
// skew_delay_line
// Fixed-depth shift register that advances only when en is high.
// Ports:
//   clk   : clock, rising-edge active
//   rst_n : synchronous active-low reset, clears every stage
//   en    : advance enable; all stages hold when low
//   d     : word entering stage 0
//   q     : word leaving the last stage (DEPTH cycles after entry)
// -----------------------------------------------------------------------------
module skew_delay_line
    import skew_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= '0;
            end
        end else if (en) begin
            stage_reg[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/skew_feeder.sv
// -----------------------------------------------------------------------------
// skew_feeder
// Accepts matrix rows and skews the columns so that column i reaches the
// triangular array i+1 cycles after the row is accepted.
// Ports:
//   clk, rst_n  : clock and synchronous active-low reset
//   en          : global advance enable shared with the array
//   s_valid / s_ready / s_data / s_last : upstream row handshake
//   v_data, v_valid : skewed per-column element and valid flags
//   frame_done  : one-cycle pulse on the final element of a frame
//   busy        : state is not IDLE
//   err_overrun : sticky, a frame was cut off at MAX_ROWS without s_last
// -----------------------------------------------------------------------------
module skew_feeder
    import skew_pkg::*;
#(
    parameter int N_DIM    = DEFAULT_N_DIM,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int MAX_ROWS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [N_DIM*DATA_W-1:0] s_data,
    input  logic                    s_last,
    output logic [N_DIM*DATA_W-1:0] v_data,
    output logic [N_DIM-1:0]        v_valid,
    output logic                    frame_done,
    output logic                    busy,
    output logic                    err_overrun
);

    localparam int CNT_W = $clog2(MAX_ROWS + 1);

    state_t           state_reg;
    logic [CNT_W-1:0] row_cnt_reg;
    logic             err_overrun_reg;

    logic accept;
    logic at_max;
    logic terminating;
    logic last_q;

    // s_ready already folds in en and rst_n, so accept implies en=1.
    assign s_ready     = en && rst_n && (state_reg != DRAIN);
    assign accept      = s_valid && s_ready;
    // Counter holds rows accepted so far; at MAX_ROWS-1 the current row is row MAX_ROWS.
    assign at_max      = (row_cnt_reg == CNT_W'(MAX_ROWS - 1));
    assign terminating = s_last || at_max;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            row_cnt_reg     <= '0;
            err_overrun_reg <= 1'b0;
        end else if (en) begin
            if (accept) begin
                if (terminating) begin
                    row_cnt_reg <= '0;
                    state_reg   <= DRAIN;
                    if (!s_last) begin
                        err_overrun_reg <= 1'b1;
                    end
                end else begin
                    row_cnt_reg <= row_cnt_reg + 1'b1;
                    state_reg   <= STREAM;
                end
            end else if (state_reg == DRAIN && frame_done) begin
                state_reg <= IDLE;
            end
        end
    end

    // One delay line per column; any non-accept cycle with en high pushes a
    // zero bubble. The last column also carries the end-of-frame marker.
    genvar gi;
    generate
        for (gi = 0; gi < N_DIM; gi++) begin : g_col
            logic [DATA_W-1:0] col_d;
            logic [DATA_W-1:0] col_q;
            logic              col_vq;

            assign col_d = accept ? s_data[gi*DATA_W +: DATA_W] : '0;

            if (gi == N_DIM - 1) begin : g_last
                logic [DATA_W+1:0] line_q;

                skew_delay_line #(
                    .DEPTH (gi + 1),
                    .WIDTH (DATA_W + 2)
                ) u_delay (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .en    (en),
                    .d     ({accept && terminating, accept, col_d}),
                    .q     (line_q)
                );

                assign last_q = line_q[DATA_W+1];
                assign col_vq = line_q[DATA_W];
                assign col_q  = line_q[DATA_W-1:0];
            end else begin : g_mid
                logic [DATA_W:0] line_q;

                skew_delay_line #(
                    .DEPTH (gi + 1),
                    .WIDTH (DATA_W + 1)
                ) u_delay (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .en    (en),
                    .d     ({accept, col_d}),
                    .q     (line_q)
                );

                assign col_vq = line_q[DATA_W];
                assign col_q  = line_q[DATA_W-1:0];
            end

            assign v_data[gi*DATA_W +: DATA_W] = col_q;
            assign v_valid[gi]                 = col_vq;
        end
    endgenerate

    assign frame_done  = v_valid[N_DIM-1] && last_q;
    assign busy        = (state_reg != IDLE);
    assign err_overrun = err_overrun_reg;

endmodule

// File: tb/tb_skew_feeder.sv
module tb_skew_feeder;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        s_valid;
    logic        s_ready;
    logic [47:0] s_data;
    logic        s_last;
    logic [47:0] v_data;
    logic [2:0]  v_valid;
    logic        frame_done;
    logic        busy;
    logic        err_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    skew_feeder #(
        .N_DIM    (3),
        .DATA_W   (16),
        .MAX_ROWS (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .v_data      (v_data),
        .v_valid     (v_valid),
        .frame_done  (frame_done),
        .busy        (busy),
        .err_overrun (err_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sv, input logic [47:0] d, input logic last, input logic e);
        s_valid = sv;
        s_data  = d;
        s_last  = last;
        en      = e;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 48'h0003_0002_0001, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_s_ready got=%b exp=0", s_ready);
        end
        step();
        step();
        n_checks++;
        if (v_valid !== 3'b000 || v_data !== 48'h0 || frame_done !== 1'b0 ||
            busy !== 1'b0 || err_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got vv=%b vd=%h fd=%b busy=%b err=%b exp all zero",
                     v_valid, v_data, frame_done, busy, err_overrun);
        end
        rst_n = 1'b1;
        drive(1'b0, 48'h0, 1'b0, 1'b1);
        step();
        $display("reset: outputs cleared");
    endtask

    task automatic test_back_to_back();
        logic        in_v [6] = '{1, 1, 1, 0, 0, 0};
        logic        in_l [6] = '{0, 0, 1, 0, 0, 0};
        logic [47:0] in_d [6] = '{48'h0003_0002_0001, 48'h0006_0005_0004,
                                  48'h0009_0008_0007, 48'h0, 48'h0, 48'h0};
        logic [47:0] ex_d [6] = '{48'h0000_0000_0001, 48'h0000_0002_0004,
                                  48'h0003_0005_0007, 48'h0006_0008_0000,
                                  48'h0009_0000_0000, 48'h0};
        logic [2:0]  ex_v [6] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
        logic        ex_f [6] = '{0, 0, 0, 0, 1, 0};
        logic        ex_r [6] = '{1, 1, 1, 0, 0, 0};
        for (int c = 0; c < 6; c++) begin
            drive(in_v[c], in_d[c], in_l[c], 1'b1);
            #1;
            n_checks++;
            if (s_ready !== ex_r[c]) begin
                n_fail++;
                $display("FAIL b2b_s_ready c%0d got=%b exp=%b", c, s_ready, ex_r[c]);
            end
            step();
            n_checks++;
            if (v_data !== ex_d[c] || v_valid !== ex_v[c] || frame_done !== ex_f[c]) begin
                n_fail++;
                $display("FAIL b2b_out c%0d got vd=%h vv=%b fd=%b exp vd=%h vv=%b fd=%b",
                         c + 1, v_data, v_valid, frame_done, ex_d[c], ex_v[c], ex_f[c]);
            end
            $display("b2b cycle %0d: vd=%h vv=%b fd=%b", c + 1, v_data, v_valid, frame_done);
        end
        n_checks++;
        if (busy !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_idle got busy=%b s_ready=%b exp busy=0 s_ready=1", busy, s_ready);
        end
    endtask

    task automatic test_gap();
        logic        in_v [6] = '{1, 0, 1, 0, 0, 0};
        logic        in_l [6] = '{0, 0, 1, 0, 0, 0};
        logic [47:0] in_d [6] = '{48'h0003_0002_0001, 48'h0, 48'h0006_0005_0004,
                                  48'h0, 48'h0, 48'h0};
        logic [47:0] ex_d [6] = '{48'h0000_0000_0001, 48'h0000_0002_0000,
                                  48'h0003_0000_0004, 48'h0000_0005_0000,
                                  48'h0006_0000_0000, 48'h0};
        logic [2:0]  ex_v [6] = '{3'b001, 3'b010, 3'b101, 3'b010, 3'b100, 3'b000};
        logic        ex_f [6] = '{0, 0, 0, 0, 1, 0};
        logic        ex_r [6] = '{1, 1, 1, 0, 0, 0};
        for (int c = 0; c < 6; c++) begin
            drive(in_v[c], in_d[c], in_l[c], 1'b1);
            #1;
            n_checks++;
            if (s_ready !== ex_r[c]) begin
                n_fail++;
                $display("FAIL gap_s_ready c%0d got=%b exp=%b", c, s_ready, ex_r[c]);
            end
            step();
            n_checks++;
            if (v_data !== ex_d[c] || v_valid !== ex_v[c] || frame_done !== ex_f[c]) begin
                n_fail++;
                $display("FAIL gap_out c%0d got vd=%h vv=%b fd=%b exp vd=%h vv=%b fd=%b",
                         c + 1, v_data, v_valid, frame_done, ex_d[c], ex_v[c], ex_f[c]);
            end
            $display("gap cycle %0d: vd=%h vv=%b fd=%b", c + 1, v_data, v_valid, frame_done);
        end
    endtask

    task automatic test_en_stall();
        logic        in_v [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        logic        in_l [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
        logic        in_e [8] = '{1, 0, 0, 1, 1, 1, 1, 1};
        logic [47:0] in_d [8] = '{48'h0003_0002_0001, 48'h0006_0005_0004,
                                  48'h0006_0005_0004, 48'h0006_0005_0004,
                                  48'h0009_0008_0007, 48'h0, 48'h0, 48'h0};
        logic [47:0] ex_d [8] = '{48'h0000_0000_0001, 48'h0000_0000_0001,
                                  48'h0000_0000_0001, 48'h0000_0002_0004,
                                  48'h0003_0005_0007, 48'h0006_0008_0000,
                                  48'h0009_0000_0000, 48'h0};
        logic [2:0]  ex_v [8] = '{3'b001, 3'b001, 3'b001, 3'b011,
                                  3'b111, 3'b110, 3'b100, 3'b000};
        logic        ex_f [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        logic        ex_r [8] = '{1, 0, 0, 1, 1, 0, 0, 0};
        for (int c = 0; c < 8; c++) begin
            drive(in_v[c], in_d[c], in_l[c], in_e[c]);
            #1;
            n_checks++;
            if (s_ready !== ex_r[c]) begin
                n_fail++;
                $display("FAIL stall_s_ready c%0d got=%b exp=%b", c, s_ready, ex_r[c]);
            end
            step();
            n_checks++;
            if (v_data !== ex_d[c] || v_valid !== ex_v[c] || frame_done !== ex_f[c]) begin
                n_fail++;
                $display("FAIL stall_out c%0d got vd=%h vv=%b fd=%b exp vd=%h vv=%b fd=%b",
                         c + 1, v_data, v_valid, frame_done, ex_d[c], ex_v[c], ex_f[c]);
            end
            $display("stall cycle %0d: en=%b vd=%h vv=%b fd=%b",
                     c + 1, in_e[c], v_data, v_valid, frame_done);
        end
    endtask

    // Single-row frame: frame_done must appear exactly 3 cycles after the accept cycle.
    task automatic single_row_frame(input string tag);
        logic [2:0] ex_fd;
        ex_fd = 3'b100;
        drive(1'b1, 48'h000C_000B_000A, 1'b1, 1'b1);
        #1;
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_single_ready got=%b exp=1", tag, s_ready);
        end
        for (int j = 0; j < 3; j++) begin
            step();
            drive(1'b0, 48'h0, 1'b0, 1'b1);
            n_checks++;
            if (frame_done !== ex_fd[j]) begin
                n_fail++;
                $display("FAIL %s_single_fd +%0d got=%b exp=%b", tag, j + 1, frame_done, ex_fd[j]);
            end
        end
        n_checks++;
        if (v_data[47:32] !== 16'h000C) begin
            n_fail++;
            $display("FAIL %s_single_col2 got=%h exp=000c", tag, v_data[47:32]);
        end
        step();
        $display("%s: single-row frame done", tag);
    endtask

    task automatic test_overrun();
        logic [15:0] base;
        logic [2:0]  ex_fd;
        ex_fd = 3'b010;
        for (int k = 0; k < 8; k++) begin
            base = 16'(k * 16);
            drive(1'b1, {base + 16'd2, base + 16'd1, base}, 1'b0, 1'b1);
            #1;
            n_checks++;
            if (s_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL ovr_ready row%0d got=%b exp=1", k, s_ready);
            end
            step();
            n_checks++;
            if (err_overrun !== (k == 7)) begin
                n_fail++;
                $display("FAIL ovr_err row%0d got=%b exp=%b", k, err_overrun, (k == 7));
            end
            $display("overrun row %0d accepted: err=%b", k, err_overrun);
        end
        for (int j = 0; j < 3; j++) begin
            drive(1'b0, 48'h0, 1'b0, 1'b1);
            #1;
            n_checks++;
            if (s_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ovr_drain_ready +%0d got=%b exp=0", j, s_ready);
            end
            step();
            n_checks++;
            if (frame_done !== ex_fd[j]) begin
                n_fail++;
                $display("FAIL ovr_fd +%0d got=%b exp=%b", j + 2, frame_done, ex_fd[j]);
            end
            if (j == 1) begin
                n_checks++;
                if (v_data[47:32] !== 16'd114) begin
                    n_fail++;
                    $display("FAIL ovr_last_col2 got=%0d exp=114", v_data[47:32]);
                end
            end
        end
        single_row_frame("ovr");
        n_checks++;
        if (err_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_sticky got=%b exp=1", err_overrun);
        end
    endtask

    task automatic test_reset_midframe();
        drive(1'b1, 48'h0003_0002_0001, 1'b0, 1'b1);
        step();
        drive(1'b1, 48'h0006_0005_0004, 1'b0, 1'b1);
        step();
        rst_n = 1'b0;
        drive(1'b1, 48'h0009_0008_0007, 1'b1, 1'b1);
        #1;
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_ready got=%b exp=0", s_ready);
        end
        step();
        n_checks++;
        if (v_valid !== 3'b000 || v_data !== 48'h0 || busy !== 1'b0 ||
            frame_done !== 1'b0 || err_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_clear got vv=%b vd=%h busy=%b fd=%b err=%b exp all zero",
                     v_valid, v_data, busy, frame_done, err_overrun);
        end
        rst_n = 1'b1;
        drive(1'b0, 48'h0, 1'b0, 1'b1);
        for (int j = 0; j < 4; j++) begin
            step();
            n_checks++;
            if (frame_done !== 1'b0 || v_valid !== 3'b000) begin
                n_fail++;
                $display("FAIL rstmid_quiet +%0d got fd=%b vv=%b exp fd=0 vv=000",
                         j, frame_done, v_valid);
            end
        end
        $display("reset mid-frame: in-flight data discarded");
        single_row_frame("rstmid");
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        test_reset();
        test_back_to_back();
        test_gap();
        test_en_stall();
        test_overrun();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
